// File: rtl/float_sub_arb_if.sv
// Requester, sub-unit and response signals of float_sub_arb, bundled as one port.
// slave = arbiter side, master = the clients plus the float_sub instance.
interface float_sub_arb_if #(
    parameter int unsigned CW = 16
);
    logic          req0_valid;
    logic [31:0]   req0_v1;
    logic [31:0]   req0_v2;
    logic          req0_ready;
    logic          req1_valid;
    logic [31:0]   req1_v1;
    logic [31:0]   req1_v2;
    logic          req1_ready;
    logic [31:0]   sub_v1;
    logic [31:0]   sub_v2;
    logic [31:0]   sub_res;
    logic          rsp0_valid;
    logic          rsp1_valid;
    logic [31:0]   rsp_data;
    logic          busy;
    logic [CW-1:0] done0_cnt;
    logic [CW-1:0] done1_cnt;

    modport slave (
        input  req0_valid, req0_v1, req0_v2, req1_valid, req1_v1, req1_v2, sub_res,
        output req0_ready, req1_ready, sub_v1, sub_v2, rsp0_valid, rsp1_valid,
               rsp_data, busy, done0_cnt, done1_cnt
    );

    modport master (
        output req0_valid, req0_v1, req0_v2, req1_valid, req1_v1, req1_v2, sub_res,
        input  req0_ready, req1_ready, sub_v1, sub_v2, rsp0_valid, rsp1_valid,
               rsp_data, busy, done0_cnt, done1_cnt
    );
endinterface

// File: rtl/float_sub_arb.sv
// Round-robin arbiter in front of one shared, fully pipelined float_sub unit.
// A tag shift register tracks in-flight ops and steers each result back to its requester.
module float_sub_arb #(
    parameter int unsigned LAT = 7,
    parameter int unsigned CW  = 16
) (
    input logic            clk,
    input logic            rst,
    float_sub_arb_if.slave bus
);
    typedef enum logic {
        PREF_0 = 1'b0,
        PREF_1 = 1'b1
    } rr_t;

    rr_t           rr;
    logic          grant0;
    logic          grant1;
    logic          accept;
    logic [LAT-1:0] tag_v;
    logic [LAT-1:0] tag_id;
    logic [31:0]   sub_v1_q;
    logic [31:0]   sub_v2_q;
    logic [31:0]   rsp_data_q;
    logic          rsp0_q;
    logic          rsp1_q;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    // Grant is also ready, so an accept is simply any grant.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (bus.req0_valid && (!bus.req1_valid || rr == PREF_0)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign accept = grant0 | grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr         <= PREF_0;
            tag_v      <= '0;
            tag_id     <= '0;
            sub_v1_q   <= '0;
            sub_v2_q   <= '0;
            rsp_data_q <= '0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            cnt0       <= '0;
            cnt1       <= '0;
        end else begin
            tag_v  <= {tag_v[LAT-2:0], accept};
            tag_id <= {tag_id[LAT-2:0], grant1};
            if (accept) begin
                sub_v1_q <= grant1 ? bus.req1_v1 : bus.req0_v1;
                sub_v2_q <= grant1 ? bus.req1_v2 : bus.req0_v2;
                rr       <= grant1 ? PREF_0 : PREF_1;
            end
            // The last tag stage describes the op whose result is on sub_res now.
            rsp0_q <= tag_v[LAT-1] && !tag_id[LAT-1];
            rsp1_q <= tag_v[LAT-1] &&  tag_id[LAT-1];
            if (tag_v[LAT-1]) begin
                rsp_data_q <= bus.sub_res;
                if (tag_id[LAT-1]) begin
                    cnt1 <= cnt1 + CW'(1);
                end else begin
                    cnt0 <= cnt0 + CW'(1);
                end
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.sub_v1     = sub_v1_q;
    assign bus.sub_v2     = sub_v2_q;
    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.busy       = (|tag_v) | rsp0_q | rsp1_q;
    assign bus.done0_cnt  = cnt0;
    assign bus.done1_cnt  = cnt1;
endmodule

// File: tb/tb_float_sub_arb.sv
// Bench for float_sub_arb: a stand-in float_sub pipeline plus a queue-based model of
// grants and due responses, compared cycle by cycle from one task per scenario.
module tb_float_sub_arb;
    localparam int unsigned LAT = 7;
    localparam int unsigned CW  = 4;

    logic clk;
    logic rst;

    float_sub_arb_if #(.CW(CW)) bus ();

    float_sub_arb #(.LAT(LAT), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in sub unit: known pairs give true IEEE differences, anything else a fixed mix.
    function automatic logic [31:0] sub_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
        if (a == 32'h4120_0000 && b == 32'h4080_0000) return 32'h40C0_0000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
    endfunction

    logic [31:0] spipe [LAT-1];
    initial for (int k = 0; k < int'(LAT) - 1; k++) spipe[k] = '0;
    always @(posedge clk) begin
        spipe[0] <= sub_fn(bus.sub_v1, bus.sub_v2);
        for (int k = 1; k < int'(LAT) - 1; k++) spipe[k] <= spipe[k-1];
    end
    assign bus.sub_res = spipe[LAT-2];

    // Reference model: ops due at (accept cycle + LAT + 1), delivered in order.
    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } op_t;

    op_t           pend[$];
    int            cyc;
    int            rr_m;
    logic [CW-1:0] m_cnt0;
    logic [CW-1:0] m_cnt1;
    logic [31:0]   m_data;
    int            nchk;
    int            nerr;

    function automatic int model_grant();
        if (rst) return -1;
        if (bus.req0_valid && (!bus.req1_valid || rr_m == 0)) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    function automatic logic [1:0] model_rsp();
        if (pend.size() > 0 && pend[0].due == cyc) return (pend[0].id == 0) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    task automatic tick();
        int  g;
        op_t o;
        g      = model_grant();
        o.due  = cyc + int'(LAT) + 1;
        o.id   = g;
        o.data = (g == 1) ? sub_fn(bus.req1_v1, bus.req1_v2) : sub_fn(bus.req0_v1, bus.req0_v2);
        @(posedge clk);
        if (rst) begin
            pend.delete();
            rr_m   = 0;
            m_cnt0 = '0;
            m_cnt1 = '0;
            m_data = '0;
        end else if (g >= 0) begin
            pend.push_back(o);
            rr_m = 1 - g;
        end
        cyc++;
        while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
        if (pend.size() > 0 && pend[0].due == cyc) begin
            m_data = pend[0].data;
            if (pend[0].id == 0) m_cnt0++;
            else m_cnt1++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_v1 = $urandom; bus.req0_v2 = $urandom;
        bus.req1_v1 = $urandom; bus.req1_v2 = $urandom;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            nchk++;
            if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
                nerr++;
                $display("FAIL reset_ready c%0d got %b%b want 00", c, bus.req0_ready, bus.req1_ready);
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        nchk++;
        if ({bus.rsp0_valid, bus.rsp1_valid, bus.busy} !== 3'b000 || bus.rsp_data !== 32'h0
            || bus.sub_v1 !== 32'h0 || bus.sub_v2 !== 32'h0
            || bus.done0_cnt !== '0 || bus.done1_cnt !== '0) begin
            nerr++;
            $display("FAIL reset_state got rsp=%b%b busy=%b data=%h sub=%h/%h cnt=%0d/%0d want all zero",
                     bus.rsp0_valid, bus.rsp1_valid, bus.busy, bus.rsp_data,
                     bus.sub_v1, bus.sub_v2, bus.done0_cnt, bus.done1_cnt);
        end
        tick();
    endtask

    task automatic test_single_op();
        int pulse_at;
        pulse_at = -1;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            bus.req0_valid = (c == 0);
            bus.req0_v1 = 32'h4040_0000;
            bus.req0_v2 = 32'h3F80_0000;
            @(negedge clk);
            nchk++;
            if ({bus.req0_ready, bus.req1_ready} !== {model_grant() == 0, model_grant() == 1}) begin
                nerr++;
                $display("FAIL single_ready c%0d got %b%b want %b%b", c, bus.req0_ready, bus.req1_ready,
                         model_grant() == 0, model_grant() == 1);
            end
            nchk++;
            if ({bus.rsp0_valid, bus.rsp1_valid} !== model_rsp() || bus.rsp_data !== m_data) begin
                nerr++;
                $display("FAIL single_rsp c%0d got %b%b/%h want %b/%h", c, bus.rsp0_valid, bus.rsp1_valid,
                         bus.rsp_data, model_rsp(), m_data);
            end
            if (bus.rsp0_valid === 1'b1) pulse_at = c;
            tick();
        end
        @(negedge clk);
        nchk++;
        if (pulse_at != 8 || bus.rsp_data !== 32'h4000_0000 || bus.done0_cnt !== 4'd1 || bus.busy !== 1'b0) begin
            nerr++;
            $display("FAIL single_result got pulse@%0d data=%h cnt0=%0d busy=%b want 8/40000000/1/0",
                     pulse_at, bus.rsp_data, bus.done0_cnt, bus.busy);
        end
    endtask

    task automatic test_contention();
        logic [5:0] grants;
        logic [5:0] rsps;
        int         nr;
        grants = '0;
        rsps   = '0;
        nr     = 0;
        do_reset();
        bus.req0_v1 = 32'h4040_0000; bus.req0_v2 = 32'h3F80_0000;
        bus.req1_v1 = 32'h4120_0000; bus.req1_v2 = 32'h4080_0000;
        for (int c = 0; c < 16; c++) begin
            bus.req0_valid = (c < 6);
            bus.req1_valid = (c < 6);
            @(negedge clk);
            nchk++;
            if ({bus.req0_ready, bus.req1_ready} !== {model_grant() == 0, model_grant() == 1}) begin
                nerr++;
                $display("FAIL contention_ready c%0d got %b%b want %b%b", c, bus.req0_ready, bus.req1_ready,
                         model_grant() == 0, model_grant() == 1);
            end
            if (c < 6) grants[c] = bus.req1_ready;
            nchk++;
            if ({bus.rsp0_valid, bus.rsp1_valid} !== model_rsp() || bus.rsp_data !== m_data
                || bus.busy !== (pend.size() != 0)) begin
                nerr++;
                $display("FAIL contention_rsp c%0d got %b%b/%h busy=%b want %b/%h busy=%b", c,
                         bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data, bus.busy,
                         model_rsp(), m_data, pend.size() != 0);
            end
            if (c >= 8 && c < 14) begin
                rsps[c-8] = bus.rsp1_valid;
                if (bus.rsp0_valid || bus.rsp1_valid) nr++;
            end
            tick();
        end
        @(negedge clk);
        nchk++;
        if (grants !== 6'b101010 || rsps !== 6'b101010 || nr != 6
            || bus.done0_cnt !== 4'd3 || bus.done1_cnt !== 4'd3) begin
            nerr++;
            $display("FAIL contention_summary got grants=%b rsps=%b n=%0d cnt=%0d/%0d want 101010/101010/6/3/3",
                     grants, rsps, nr, bus.done0_cnt, bus.done1_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int n1;
        int n0;
        n1 = 0;
        n0 = 0;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            bus.req1_valid = (c < 10);
            bus.req1_v1 = $urandom;
            bus.req1_v2 = $urandom;
            @(negedge clk);
            nchk++;
            if (bus.req1_ready !== (c < 10) || bus.req0_ready !== 1'b0) begin
                nerr++;
                $display("FAIL b2b_ready c%0d got %b%b want 0%b", c, bus.req0_ready, bus.req1_ready, c < 10);
            end
            nchk++;
            if ({bus.rsp0_valid, bus.rsp1_valid} !== model_rsp() || bus.rsp_data !== m_data) begin
                nerr++;
                $display("FAIL b2b_rsp c%0d got %b%b/%h want %b/%h", c, bus.rsp0_valid, bus.rsp1_valid,
                         bus.rsp_data, model_rsp(), m_data);
            end
            if (bus.rsp1_valid === 1'b1) n1++;
            if (bus.rsp0_valid === 1'b1) n0++;
            tick();
        end
        nchk++;
        if (n1 != 10 || n0 != 0) begin
            nerr++;
            $display("FAIL b2b_count got rsp1=%0d rsp0=%0d want 10/0", n1, n0);
        end
    endtask

    task automatic test_reset_midflight();
        int npulse;
        int pulse_at;
        npulse   = 0;
        pulse_at = -1;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            bus.req0_valid = (c < 3) || (c == 10);
            bus.req0_v1 = $urandom;
            bus.req0_v2 = $urandom;
            rst = (c == 4);
            @(negedge clk);
            nchk++;
            if ({bus.req0_ready, bus.req1_ready} !== {model_grant() == 0, model_grant() == 1}) begin
                nerr++;
                $display("FAIL midrst_ready c%0d got %b%b want %b%b", c, bus.req0_ready, bus.req1_ready,
                         model_grant() == 0, model_grant() == 1);
            end
            nchk++;
            if ({bus.rsp0_valid, bus.rsp1_valid} !== model_rsp() || bus.rsp_data !== m_data
                || bus.busy !== (pend.size() != 0) || bus.done0_cnt !== m_cnt0) begin
                nerr++;
                $display("FAIL midrst_rsp c%0d got %b%b/%h busy=%b cnt0=%0d want %b/%h busy=%b cnt0=%0d", c,
                         bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data, bus.busy, bus.done0_cnt,
                         model_rsp(), m_data, pend.size() != 0, m_cnt0);
            end
            if (bus.rsp0_valid === 1'b1 || bus.rsp1_valid === 1'b1) begin
                npulse++;
                pulse_at = c;
            end
            tick();
        end
        rst = 1'b0;
        nchk++;
        if (npulse != 1 || pulse_at != 18) begin
            nerr++;
            $display("FAIL midrst_pulses got n=%0d last@%0d want 1 pulse at 18", npulse, pulse_at);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 26; c++) begin
            bus.req0_valid = (c < 17);
            bus.req0_v1 = $urandom;
            bus.req0_v2 = $urandom;
            @(negedge clk);
            nchk++;
            if ({bus.rsp0_valid, bus.rsp1_valid} !== model_rsp() || bus.done0_cnt !== m_cnt0) begin
                nerr++;
                $display("FAIL wrap_rsp c%0d got %b%b cnt0=%0d want %b cnt0=%0d", c, bus.rsp0_valid,
                         bus.rsp1_valid, bus.done0_cnt, model_rsp(), m_cnt0);
            end
            tick();
        end
        @(negedge clk);
        nchk++;
        if (bus.done0_cnt !== 4'd1 || bus.busy !== 1'b0) begin
            nerr++;
            $display("FAIL wrap_count got cnt0=%0d busy=%b want 1/0", bus.done0_cnt, bus.busy);
        end
    endtask

    task automatic test_idle_gaps();
        int seen [$];
        do_reset();
        for (int c = 0; c < 16; c++) begin
            bus.req0_valid = (c == 0) || (c == 3) || (c == 4);
            bus.req0_v1 = $urandom;
            bus.req0_v2 = $urandom;
            @(negedge clk);
            nchk++;
            if ({bus.rsp0_valid, bus.rsp1_valid} !== model_rsp() || bus.rsp_data !== m_data) begin
                nerr++;
                $display("FAIL gaps_rsp c%0d got %b%b/%h want %b/%h", c, bus.rsp0_valid, bus.rsp1_valid,
                         bus.rsp_data, model_rsp(), m_data);
            end
            if (bus.rsp0_valid === 1'b1 || bus.rsp1_valid === 1'b1) seen.push_back(c);
            tick();
        end
        nchk++;
        if (seen.size() != 3 || seen[0] != 8 || seen[1] != 11 || seen[2] != 12) begin
            nerr++;
            $display("FAIL gaps_timing got %0d pulses first@%0d want 3 at 8/11/12", seen.size(),
                     (seen.size() > 0) ? seen[0] : -1);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 120; c++) begin
            bus.req0_valid = (c < 100) && ($urandom_range(0, 3) != 0);
            bus.req1_valid = (c < 100) && ($urandom_range(0, 2) != 0);
            bus.req0_v1 = $urandom; bus.req0_v2 = $urandom;
            bus.req1_v1 = $urandom; bus.req1_v2 = $urandom;
            @(negedge clk);
            nchk++;
            if ({bus.req0_ready, bus.req1_ready} !== {model_grant() == 0, model_grant() == 1}) begin
                nerr++;
                $display("FAIL random_ready c%0d got %b%b want %b%b", c, bus.req0_ready, bus.req1_ready,
                         model_grant() == 0, model_grant() == 1);
            end
            nchk++;
            if ({bus.rsp0_valid, bus.rsp1_valid} !== model_rsp() || bus.rsp_data !== m_data
                || bus.busy !== (pend.size() != 0)
                || bus.done0_cnt !== m_cnt0 || bus.done1_cnt !== m_cnt1) begin
                nerr++;
                $display("FAIL random_rsp c%0d got %b%b/%h busy=%b cnt=%0d/%0d want %b/%h busy=%b cnt=%0d/%0d",
                         c, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data, bus.busy, bus.done0_cnt,
                         bus.done1_cnt, model_rsp(), m_data, pend.size() != 0, m_cnt0, m_cnt1);
            end
            tick();
        end
    endtask

    initial begin
        nchk   = 0;
        nerr   = 0;
        cyc    = 0;
        rr_m   = 0;
        m_cnt0 = '0;
        m_cnt1 = '0;
        m_data = '0;
        rst    = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_v1 = '0; bus.req0_v2 = '0;
        bus.req1_v1 = '0; bus.req1_v2 = '0;
        #1;
        test_reset();
        test_single_op();
        test_contention();
        test_back_to_back();
        test_reset_midflight();
        test_wrap();
        test_idle_gaps();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
